// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the LSB-first parallel-to-serial shifter.
package ser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; a 2-bit word still needs one counter bit.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  // SHIFT mirrors shift_valid; there is no separate state register.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/parallel_to_serial_if.sv
// Parallel word input plus serial bit output of the serializer, bundled as one port.
interface parallel_to_serial_if #(
  parameter int width = 8
);
  logic             parallel_valid;
  logic             parallel_ready;
  logic [width-1:0] parallel_data;
  logic             serial_valid;
  logic             serial_ready;
  logic             serial_data;
  logic             serial_last;
  logic             busy;

  // Environment side: drives the word and the downstream ready.
  modport master (
    output parallel_valid, parallel_data, serial_ready,
    input  parallel_ready, serial_valid, serial_data, serial_last, busy
  );

  // Serializer side.
  modport slave (
    input  parallel_valid, parallel_data, serial_ready,
    output parallel_ready, serial_valid, serial_data, serial_last, busy
  );
endinterface

// File: rtl/parallel_to_serial_sva.sv
// Protocol checks for the serializer: output held under backpressure, no accept into a full hold.
module parallel_to_serial_sva (
  input logic clk,
  input logic rst,
  input logic serial_valid,
  input logic serial_ready,
  input logic serial_data,
  input logic serial_last,
  input logic acc,
  input logic hold_valid
);

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (serial_valid && !serial_ready) |=>
      (serial_valid && $stable(serial_data) && $stable(serial_last)));

  a_no_acc_when_held: assert property (@(posedge clk) disable iff (rst)
    !(acc && hold_valid));

endmodule

// File: rtl/parallel_to_serial.sv
// LSB-first serializer with a one-word holding register so back-to-back words stream gaplessly.
// Word accepted at edge N shows bit0 in cycle N+1; parallel_ready depends on registered state only.
module parallel_to_serial
  import ser_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  parallel_to_serial_if.slave bus
);

  localparam int CW = cnt_width(width);
  localparam logic [CW-1:0] LAST_IDX = CW'(width - 1);

  logic [width-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic             shift_valid;
  logic [width-1:0] hold_reg;
  logic             hold_valid;

  ser_state_t state;
  logic       acc;
  logic       xfer;
  logic       fin;
  logic       shifter_free;

  always_comb begin
    state        = shift_valid ? SHIFT : IDLE;
    acc          = bus.parallel_valid && !hold_valid;
    xfer         = shift_valid && bus.serial_ready;
    fin          = xfer && (bit_cnt == LAST_IDX);
    shifter_free = (state == IDLE) || fin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      shift_valid <= 1'b0;
      hold_reg    <= '0;
      hold_valid  <= 1'b0;
    end else begin
      if (shifter_free) begin
        // Held word has priority; hold full implies no accept this cycle.
        if (hold_valid) begin
          shift_reg   <= hold_reg;
          hold_valid  <= 1'b0;
          bit_cnt     <= '0;
          shift_valid <= 1'b1;
        end else if (acc) begin
          shift_reg   <= bus.parallel_data;
          bit_cnt     <= '0;
          shift_valid <= 1'b1;
        end else begin
          shift_valid <= 1'b0;
        end
      end else if (xfer) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + 1'b1;
      end

      if (acc && !shifter_free) begin
        hold_reg   <= bus.parallel_data;
        hold_valid <= 1'b1;
      end
    end
  end

  assign bus.parallel_ready = !hold_valid;
  assign bus.serial_valid   = shift_valid;
  assign bus.serial_data    = shift_reg[0];
  assign bus.serial_last    = shift_valid && (bit_cnt == LAST_IDX);
  assign bus.busy           = shift_valid || hold_valid;

  parallel_to_serial_sva u_sva (
    .clk          (clk),
    .rst          (rst),
    .serial_valid (shift_valid),
    .serial_ready (bus.serial_ready),
    .serial_data  (shift_reg[0]),
    .serial_last  (bus.serial_last),
    .acc          (acc),
    .hold_valid   (hold_valid)
  );

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: directed cases plus a random loopback checked by a bit scoreboard.
module tb_parallel_to_serial;

  typedef struct packed {
    logic d;
    logic last;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parallel_to_serial_if #(.width(8)) pif ();
  parallel_to_serial_if #(.width(2)) pif2 ();

  parallel_to_serial #(.width(8)) u_dut (.clk(clk), .rst(rst), .bus(pif));
  parallel_to_serial #(.width(2)) u_dut2 (.clk(clk), .rst(rst), .bus(pif2));

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int acc_cnt  = 0;
  int last_cnt = 0;
  int word_cnt = 0;

  sb_t        bit_q[$];
  logic [7:0] word_q[$];
  logic [7:0] des = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Scoreboard: bits queued on accept, compared on transfer; deserializer rebuilds each word.
  always @(negedge clk) begin
    if (rst) begin
      bit_q.delete();
      word_q.delete();
      des = '0;
    end else begin
      if (pif.serial_valid && pif.serial_ready) begin
        chk("sb_nonempty", 32'(bit_q.size() != 0), 1);
        if (bit_q.size() != 0) begin
          sb_t e;
          e = bit_q.pop_front();
          chk("sb_data", pif.serial_data, e.d);
          chk("sb_last", pif.serial_last, e.last);
        end
        des = {pif.serial_data, des[7:1]};
        if (pif.serial_last) begin
          last_cnt++;
          if (word_q.size() != 0) begin
            chk("word", des, word_q.pop_front());
            word_cnt++;
          end
        end
      end
      if (pif.parallel_valid && pif.parallel_ready) begin
        logic [7:0] w;
        w = pif.parallel_data;
        acc_cnt++;
        word_q.push_back(w);
        for (int i = 0; i < 8; i++) bit_q.push_back('{d: w[i], last: (i == 7)});
      end
    end
  end

  initial begin
    logic [7:0]  v;
    logic [15:0] v16;
    logic [3:0]  v4;
    int idx;
    int base_acc, base_last, base_word, cyc;
    logic seen;

    pif.parallel_valid = 1'b0;
    pif.parallel_data  = '0;
    pif.serial_ready   = 1'b1;
    pif2.parallel_valid = 1'b0;
    pif2.parallel_data  = '0;
    pif2.serial_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", pif.serial_valid, 0);
    chk("rst_data", pif.serial_data, 0);
    chk("rst_last", pif.serial_last, 0);
    chk("rst_busy", pif.busy, 0);
    chk("rst_ready", pif.parallel_ready, 1);
    @(posedge clk); #1;

    // Single word A5.
    v = 8'hA5;
    pif.parallel_valid = 1'b1;
    pif.parallel_data  = v;
    @(posedge clk); #1;
    pif.parallel_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("a5_valid", pif.serial_valid, 1);
      chk("a5_bit", pif.serial_data, v[i]);
      chk("a5_last", pif.serial_last, (i == 7));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("a5_done", pif.serial_valid, 0);
    @(posedge clk); #1;

    // 3C then C3 back-to-back through the hold register.
    v16 = 16'hC33C;
    pif.parallel_valid = 1'b1;
    pif.parallel_data  = 8'h3C;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) pif.parallel_data = 8'hC3;
      if (i == 1) pif.parallel_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid", pif.serial_valid, 1);
      chk("b2b_bit", pif.serial_data, v16[i]);
      if (i >= 1 && i <= 7) chk("b2b_ready_low", pif.parallel_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("b2b_done", pif.serial_valid, 0);
    @(posedge clk); #1;

    // F0 with a three-cycle stall.
    v = 8'hF0;
    pif.parallel_valid = 1'b1;
    pif.parallel_data  = v;
    @(posedge clk); #1;
    pif.parallel_valid = 1'b0;
    idx = 0;
    for (int c = 1; c <= 11; c++) begin
      pif.serial_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      chk("stall_valid", pif.serial_valid, 1);
      chk("stall_bit", pif.serial_data, v[idx[2:0]]);
      if (!pif.serial_ready) chk("stall_idx", idx, 2);
      if (pif.serial_ready && idx == 7) chk("stall_last", pif.serial_last, 1);
      if (pif.serial_ready) idx++;
      @(posedge clk); #1;
    end
    pif.serial_ready = 1'b1;
    @(negedge clk);
    chk("stall_done", pif.serial_valid, 0);
    @(posedge clk); #1;

    // Reset mid-word with a word held.
    pif.parallel_valid = 1'b1;
    pif.parallel_data  = 8'h81;
    @(posedge clk); #1;
    pif.parallel_data  = 8'h7E;
    @(posedge clk); #1;
    pif.parallel_valid = 1'b0;
    @(negedge clk);
    chk("mid_held", pif.parallel_ready, 0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", pif.serial_valid, 0);
    chk("mrst_data", pif.serial_data, 0);
    chk("mrst_last", pif.serial_last, 0);
    chk("mrst_busy", pif.busy, 0);
    chk("mrst_ready", pif.parallel_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | pif.serial_valid;
    end
    chk("mrst_no_resume", seen, 0);
    @(posedge clk); #1;

    // Random loopback, 1000 words.
    base_acc  = acc_cnt;
    base_last = last_cnt;
    base_word = word_cnt;
    cyc = 0;
    while ((acc_cnt - base_acc) < 1000 && cyc < 40000) begin
      pif.parallel_valid = 1'($urandom_range(0, 1));
      pif.parallel_data  = 8'($urandom);
      pif.serial_ready   = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_words_in", acc_cnt - base_acc, 1000);
    pif.parallel_valid = 1'b0;
    pif.serial_ready   = 1'b1;
    cyc = 0;
    while (pif.busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_drained", pif.busy, 0);
    chk("rand_last_cnt", last_cnt - base_last, acc_cnt - base_acc);
    chk("rand_word_cnt", word_cnt - base_word, acc_cnt - base_acc);

    // width=2 instance.
    v4 = 4'b1001;
    pif2.parallel_valid = 1'b1;
    pif2.parallel_data  = 2'b01;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) pif2.parallel_data = 2'b10;
      if (i == 1) pif2.parallel_valid = 1'b0;
      @(negedge clk);
      chk("w2_valid", pif2.serial_valid, 1);
      chk("w2_bit", pif2.serial_data, v4[i]);
      chk("w2_last", pif2.serial_last, (i == 1 || i == 3));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("w2_done", pif2.serial_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
